// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and decoded key/event outputs of the PS/2 set-2 key decoder.
// The master side is the PS/2 receiver / consumer; the slave side is the decoder.
interface ps2_key_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [9:0] key_held;
  logic [9:0] key_press;
  logic [9:0] key_release;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       seq_abort;

  modport master (
    output byte_in, byte_valid,
    input  key_held, key_press, key_release,
    input  evt_valid, evt_code, evt_ext, evt_break, seq_abort
  );

  modport slave (
    input  byte_in, byte_valid,
    output key_held, key_press, key_release,
    output evt_valid, evt_code, evt_ext, evt_break, seq_abort
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: make/break/E0/E1 sequences become held state,
// press/release edges and raw events; a stalled prefix is dropped by timeout.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_WIDTH       = 20
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT_CYCLES);

  state_t              state, state_n, dec_state;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_n;
  logic [2:0]          skip, skip_n;
  logic                timeout_hit;
  logic                is_prefix, is_swallow;
  logic                emit, emit_ext, emit_brk;
  logic [9:0]          key_mask, held_n, press_n, release_n;

  function automatic logic [9:0] map_key(input logic ext, input logic [7:0] code);
    logic [9:0] m;
    m = '0;
    if (ext) begin
      case (code)
        8'h75:   m[0] = 1'b1;
        8'h72:   m[1] = 1'b1;
        8'h6B:   m[2] = 1'b1;
        8'h74:   m[3] = 1'b1;
        default: ;
      endcase
    end else begin
      case (code)
        8'h1D:   m[4] = 1'b1;
        8'h1C:   m[5] = 1'b1;
        8'h1B:   m[6] = 1'b1;
        8'h23:   m[7] = 1'b1;
        8'h29:   m[8] = 1'b1;
        8'h76:   m[9] = 1'b1;
        default: ;
      endcase
    end
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
      skip   <= '0;
    end else begin
      state  <= state_n;
      to_cnt <= to_cnt_n;
      skip   <= skip_n;
    end
  end

  always_comb begin
    state_n   = state;
    to_cnt_n  = to_cnt;
    skip_n    = skip;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;

    timeout_hit = (state != IDLE) && (to_cnt == TO_MAX);
    is_prefix   = (bus.byte_in == 8'hE0) || (bus.byte_in == 8'hF0) || (bus.byte_in == 8'hE1);
    is_swallow  = (bus.byte_in == 8'hAA) || (bus.byte_in == 8'hFA) || (bus.byte_in == 8'hFE) ||
                  (bus.byte_in == 8'hEE) || (bus.byte_in == 8'h00) || (bus.byte_in == 8'hFF);

    // A timed-out prefix, or a prefix byte arriving after F0, is decoded as if
    // the FSM were already back in IDLE, so one case covers both recoveries.
    dec_state = timeout_hit ? IDLE : state;
    if ((dec_state == BRK || dec_state == EXT_BRK) && is_prefix) dec_state = IDLE;

    if (timeout_hit) begin
      state_n  = IDLE;
      to_cnt_n = '0;
      skip_n   = '0;
    end else if (state != IDLE) begin
      to_cnt_n = to_cnt + 1'b1;
    end

    if (bus.byte_valid) begin
      to_cnt_n = '0;
      case (dec_state)
        IDLE: begin
          state_n = IDLE;
          if (bus.byte_in == 8'hE0)      state_n = EXT;
          else if (bus.byte_in == 8'hF0) state_n = BRK;
          else if (bus.byte_in == 8'hE1) begin
            state_n = PAUSE;
            skip_n  = 3'd7;
          end else if (!is_swallow)      emit = 1'b1;
        end
        EXT: begin
          if (bus.byte_in == 8'hF0)      state_n = EXT_BRK;
          else if (bus.byte_in == 8'hE0) state_n = EXT;
          else begin
            state_n  = IDLE;
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        BRK: begin
          state_n  = IDLE;
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
        EXT_BRK: begin
          state_n  = IDLE;
          emit     = 1'b1;
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
        PAUSE: begin
          skip_n = skip - 1'b1;
          if (skip <= 3'd1) begin
            state_n = IDLE;
            skip_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    key_mask  = map_key(emit_ext, bus.byte_in);
    held_n    = bus.key_held;
    press_n   = '0;
    release_n = '0;
    if (emit) begin
      if (emit_brk) begin
        held_n    = bus.key_held & ~key_mask;
        release_n = bus.key_held & key_mask;
      end else begin
        held_n    = bus.key_held | key_mask;
        press_n   = ~bus.key_held & key_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.key_held    <= '0;
      bus.key_press   <= '0;
      bus.key_release <= '0;
      bus.evt_valid   <= 1'b0;
      bus.evt_code    <= '0;
      bus.evt_ext     <= 1'b0;
      bus.evt_break   <= 1'b0;
      bus.seq_abort   <= 1'b0;
    end else begin
      bus.key_held    <= held_n;
      bus.key_press   <= press_n;
      bus.key_release <= release_n;
      bus.evt_valid   <= emit;
      bus.seq_abort   <= timeout_hit;
      if (emit) begin
        bus.evt_code  <= bus.byte_in;
        bus.evt_ext   <= emit_ext;
        bus.evt_break <= emit_brk;
      end
    end
  end

endmodule
